dmem_port_arbiter: RTL and testbench

Arbitrates the single data-memory port between the pipeline's WB-stage store, its MEM-stage load, and the board debug reader that sweeps memory for the seven-segment display. Removes the static WB/MEM address mux in front of data memory. The arbiter issues pipeline stalls on port conflicts and guarantees the debug reader forward progress with a starvation limit. It sits between the EX/MEM and MEM/WB pipeline registers and data memory, and its stall output feeds the pipeline enable alongside the hazard unit.

---
 rtl/dmem_port_arbiter_if.sv | 41 ++++
 rtl/dmem_port_arbiter.sv | 115 +++++++++++
 tb/tb_dmem_port_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Data-memory port bundle: pipeline store/load requests, debug reader
// requests, the shared memory port and the arbiter status outputs.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              st_req;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic              st_half;
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [1:0]        mem_mode;
  logic [31:0]       ld_data;
  logic              pipe_stall;
  logic              dbg_busy;
  logic              dbg_valid;
  logic [31:0]       dbg_data;
  logic [31:0]       stall_count;

  // Arbiter side
  modport slave (
    input  st_req, st_addr, st_data, st_half, ld_req, ld_addr,
           dbg_req, dbg_addr, mem_rdata,
    output mem_we, mem_addr, mem_wdata, mem_mode, ld_data,
           pipe_stall, dbg_busy, dbg_valid, dbg_data, stall_count
  );

  // Pipeline / memory / debug side
  modport master (
    output st_req, st_addr, st_data, st_half, ld_req, ld_addr,
           dbg_req, dbg_addr, mem_rdata,
    input  mem_we, mem_addr, mem_wdata, mem_mode, ld_data,
           pipe_stall, dbg_busy, dbg_valid, dbg_data, stall_count
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Single data-memory port shared by the WB-stage store, the MEM-stage load
// and the seven-segment debug reader. Store beats load beats debug, except
// that a debug read starved for STARVE_LIMIT cycles takes the port for one
// cycle and stalls the pipeline.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no debug read pending; dbg_req accepted here
// S_WAIT  | debug read pending; granted when the CPU leaves the port free
// S_FORCE | starvation limit hit; debug owns the port, CPU stalled
// S_DONE  | dbg_data holds the read word; dbg_valid pulses
module dmem_port_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input logic              clk,
  input logic              in_RST,
  dmem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FORCE, S_DONE} state_e;

  localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_LIMIT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0] dbg_addr_q, dbg_addr_d;
  logic [31:0]       dbg_data_q, dbg_data_d;
  logic [31:0]       stall_count_q, stall_count_d;

  logic              port_busy;
  logic              grant_st, grant_ld, grant_dbg;
  logic              stall;
  logic [ADDR_W-1:0] addr_sel;

  assign port_busy = bus.st_req | bus.ld_req;

  // Debug-read sequencing and starvation counting
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    dbg_addr_d   = dbg_addr_q;
    dbg_data_d   = dbg_data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.dbg_req) begin
          state_d      = S_WAIT;
          dbg_addr_d   = bus.dbg_addr;
          starve_cnt_d = '0;
        end
      end
      S_WAIT: begin
        if (!port_busy) begin
          state_d    = S_DONE;
          dbg_data_d = bus.mem_rdata;
        end else if (starve_cnt_q == STARVE_LAST) begin
          state_d = S_FORCE;
        end else begin
          starve_cnt_d = starve_cnt_q + 1'b1;
        end
      end
      S_FORCE: begin
        state_d    = S_DONE;
        dbg_data_d = bus.mem_rdata;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Port grant, address steering and stall generation
  always_comb begin
    grant_dbg = (state_q == S_FORCE) | ((state_q == S_WAIT) & ~port_busy);
    grant_st  = (state_q != S_FORCE) & bus.st_req;
    grant_ld  = (state_q != S_FORCE) & ~bus.st_req & bus.ld_req;
    stall     = (bus.st_req & bus.ld_req) | ((state_q == S_FORCE) & port_busy);
    addr_sel  = '0;
    if (grant_st)       addr_sel = bus.st_addr;
    else if (grant_ld)  addr_sel = bus.ld_addr;
    else if (grant_dbg) addr_sel = dbg_addr_q;
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 32'hFFFF_FFFF))
      stall_count_d = stall_count_q + 32'd1;
  end

  assign bus.mem_we      = grant_st;
  assign bus.mem_addr    = addr_sel;
  assign bus.mem_wdata   = bus.st_data;
  assign bus.mem_mode    = grant_st ? {bus.st_half, 1'b0} : 2'b00;
  assign bus.ld_data     = grant_ld ? bus.mem_rdata : 32'd0;
  assign bus.pipe_stall  = stall;
  assign bus.dbg_busy    = (state_q != S_IDLE);
  assign bus.dbg_valid   = (state_q == S_DONE);
  assign bus.dbg_data    = dbg_data_q;
  assign bus.stall_count = stall_count_q;

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!in_RST) begin
      state_q       <= S_IDLE;
      starve_cnt_q  <= '0;
      dbg_addr_q    <= '0;
      dbg_data_q    <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      dbg_addr_q    <= dbg_addr_d;
      dbg_data_q    <= dbg_data_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a word-addressed memory model
// and a scoreboard: stimulus pushes expected debug/load results, a monitor
// pops and compares whenever the arbiter presents them.
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic in_RST;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic ld_tag = 1'b0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } dbg_exp_t;

  dbg_exp_t    exp_dbg_q[$];
  logic [31:0] exp_ld_q[$];
  logic [31:0] mem [0:4095];

  dmem_port_arbiter_if #(.ADDR_W(12)) bus();

  dmem_port_arbiter #(.ADDR_W(12), .STARVE_LIMIT(8), .CNT_W(4)) dut (
    .clk    (clk),
    .in_RST (in_RST),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bus.dbg_valid === 1'b1) begin
      if (exp_dbg_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL dbg_unexpected: dbg_valid with data %h at cycle %0d, none expected", bus.dbg_data, cyc);
      end else begin
        dbg_exp_t e;
        e = exp_dbg_q.pop_front();
        check("dbg_data", bus.dbg_data, e.data);
        check("dbg_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (ld_tag && bus.ld_req && !bus.pipe_stall) begin
      if (exp_ld_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL ld_unexpected: load completed with %h, none expected", bus.ld_data);
      end else begin
        check("ld_data", bus.ld_data, exp_ld_q.pop_front());
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.st_req = 0; bus.st_addr = '0; bus.st_data = '0; bus.st_half = 0;
    bus.ld_req = 0; bus.ld_addr = '0; bus.dbg_req = 0; bus.dbg_addr = '0;
    ld_tag = 0;
  endtask

  initial begin
    int stalls;
    dbg_exp_t e;
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    mem[12'h020] = 32'h1234_5678;

    // Reset with every request high
    in_RST = 1'b0;
    bus.st_req = 1; bus.st_addr = 12'h0FF; bus.st_data = 32'h0; bus.st_half = 0;
    bus.ld_req = 1; bus.ld_addr = 12'h0FF; bus.dbg_req = 1; bus.dbg_addr = 12'h020;
    ld_tag = 0;
    repeat (2) @(posedge clk);
    #1;
    in_RST = 1'b1;
    idle_inputs();
    @(negedge clk);
    check("rst_dbg_busy", 32'(bus.dbg_busy), 32'd0);
    check("rst_dbg_valid", 32'(bus.dbg_valid), 32'd0);
    check("rst_dbg_data", bus.dbg_data, 32'd0);
    check("rst_stall_count", bus.stall_count, 32'd0);

    // Store then load to the same address
    next_cycle();
    bus.st_req = 1; bus.st_addr = 12'h010; bus.st_data = 32'hDEAD_BEEF;
    @(negedge clk);
    check("st_stall", 32'(bus.pipe_stall), 32'd0);
    check("st_we", 32'(bus.mem_we), 32'd1);
    check("st_addr", 32'(bus.mem_addr), 32'h010);
    check("st_mode", 32'(bus.mem_mode), 32'd0);
    next_cycle();
    bus.st_req = 0;
    bus.ld_req = 1; bus.ld_addr = 12'h010; ld_tag = 1;
    exp_ld_q.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    check("ld_stall", 32'(bus.pipe_stall), 32'd0);
    check("ld_we", 32'(bus.mem_we), 32'd0);
    next_cycle();
    idle_inputs();

    // Store/load conflict, halfword store
    next_cycle();
    bus.st_req = 1; bus.st_addr = 12'h030; bus.st_data = 32'hCAFE_F00D; bus.st_half = 1;
    bus.ld_req = 1; bus.ld_addr = 12'h010; ld_tag = 1;
    exp_ld_q.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    check("cf_we", 32'(bus.mem_we), 32'd1);
    check("cf_addr", 32'(bus.mem_addr), 32'h030);
    check("cf_mode", 32'(bus.mem_mode), 32'd2);
    check("cf_stall", 32'(bus.pipe_stall), 32'd1);
    check("cf_ld_data_blocked", bus.ld_data, 32'd0);
    next_cycle();
    bus.st_req = 0; bus.st_half = 0;
    @(negedge clk);
    check("cf_stall_count", bus.stall_count, 32'd1);
    check("cf_ld_stall", 32'(bus.pipe_stall), 32'd0);
    check("cf_ld_addr", 32'(bus.mem_addr), 32'h010);
    next_cycle();
    idle_inputs();

    // Idle-port debug read; a second request while busy is ignored
    next_cycle();
    bus.dbg_req = 1; bus.dbg_addr = 12'h020;
    e.data = 32'h1234_5678; e.cyc = cyc + 2;
    exp_dbg_q.push_back(e);
    next_cycle();
    bus.dbg_addr = 12'h010;
    @(negedge clk);
    check("dbg_busy_wait", 32'(bus.dbg_busy), 32'd1);
    check("dbg_wait_addr", 32'(bus.mem_addr), 32'h020);
    next_cycle();
    bus.dbg_req = 0;
    for (int i = 0; i < 20; i++) begin
      if (exp_dbg_q.size() == 0) break;
      next_cycle();
    end
    check("dbg_idle_timeout", 32'(exp_dbg_q.size()), 32'd0);
    @(negedge clk);
    check("dbg_busy_after", 32'(bus.dbg_busy), 32'd0);

    // Starvation: load held high, debug forced after 8 WAIT cycles
    next_cycle();
    bus.ld_req = 1; bus.ld_addr = 12'h010;
    bus.dbg_req = 1; bus.dbg_addr = 12'h030;
    e.data = 32'hCAFE_F00D; e.cyc = cyc + 10;
    exp_dbg_q.push_back(e);
    stalls = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.pipe_stall) stalls++;
      if (k == 8) check("sv_wait_busy", 32'(bus.dbg_busy), 32'd1);
      if (k == 9) begin
        check("sv_force_stall", 32'(bus.pipe_stall), 32'd1);
        check("sv_force_addr", 32'(bus.mem_addr), 32'h030);
        check("sv_force_ld_data", bus.ld_data, 32'd0);
      end
      next_cycle();
      bus.dbg_req = 0;
    end
    bus.ld_req = 0;
    check("sv_stall_cycles", 32'(stalls), 32'd1);
    check("sv_dbg_delivered", 32'(exp_dbg_q.size()), 32'd0);
    @(negedge clk);
    check("sv_stall_count", bus.stall_count, 32'd2);

    // Abort: reset while in WAIT drops the debug read
    next_cycle();
    bus.ld_req = 1; bus.ld_addr = 12'h010;
    bus.dbg_req = 1; bus.dbg_addr = 12'h020;
    next_cycle();
    bus.dbg_req = 0;
    @(negedge clk);
    check("ab_busy_before", 32'(bus.dbg_busy), 32'd1);
    next_cycle();
    in_RST = 1'b0;
    next_cycle();
    in_RST = 1'b1;
    @(negedge clk);
    check("ab_busy_after", 32'(bus.dbg_busy), 32'd0);
    check("ab_stall_count", bus.stall_count, 32'd0);
    repeat (12) next_cycle();
    idle_inputs();
    repeat (2) next_cycle();
    check("end_dbg_queue", 32'(exp_dbg_q.size()), 32'd0);
    check("end_ld_queue", 32'(exp_ld_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time limit
  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at cycle %0d, expected to have finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
